// File: rtl/ram_wr_pkg.sv
// Shared widths, depth and FSM encoding for the RAM write-side controller.
// No logic of its own; imported by ram_write_ctrl.
package ram_wr_pkg;

    localparam int RAM_ADDR_W       = 5;
    localparam int RAM_DATA_W       = 4;
    localparam int RAM_DEPTH        = 32;
    localparam int DEBOUNCE_DEFAULT = 500000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2,
        HOLD  = 2'd3
    } wr_state_t;

endpackage

// File: rtl/key_debounce.sv
// Purpose: 2-FF synchronizer plus debounce of one active-low pushbutton, with a press pulse.
// Latency: raw edge -> level change after 2 + DEBOUNCE_CYCLES cycles; press is registered with it.
// Backpressure: none; press is a one-cycle pulse, so a consumer that is not listening misses it.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // Counts consecutive cycles of disagreement; any agreeing cycle starts the count over.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
                press <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_write_ctrl.sv
// Purpose: pushbutton-driven write port for the 32x4 RAM: single write or full clear sweep (option WRITE_AUTOINC_EN).
// Latency: press pulse in cycle t -> first wren in cycle t+1; raw key edge -> wren within DEBOUNCE_CYCLES+4.
// Backpressure: none; presses arriving while busy are dropped, and a held key never repeats.
module ram_write_ctrl
    import ram_wr_pkg::*;
#(
    parameter int ADDR_W          = RAM_ADDR_W,
    parameter int DATA_W          = RAM_DATA_W,
    parameter int DEPTH           = RAM_DEPTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              key_write_n,
    input  logic              key_clear_n,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [DATA_W-1:0] fill_value,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddress,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic [ADDR_W-1:0] last_addr,
    output logic [7:0]        write_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    wr_state_t         state, state_nx;
    logic              level_write, press_write;
    logic              level_clear, press_clear;
    logic [ADDR_W-1:0] single_addr;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_write (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .key_n    (key_write_n),
        .level    (level_write),
        .press    (press_write)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .key_n    (key_clear_n),
        .level    (level_clear),
        .press    (press_clear)
    );

`ifdef WRITE_AUTOINC_EN
    logic [ADDR_W-1:0] wr_ptr;
    logic              unused_sw_addr;

    assign unused_sw_addr = ^sw_addr;
    assign single_addr    = wr_ptr;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
        end else if (state == IDLE && press_clear) begin
            wr_ptr <= '0;
        end else if (state == WRITE) begin
            wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
        end
    end
`else
    assign single_addr = sw_addr;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Clear is tested first so a simultaneous write press is dropped.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (press_clear) begin
                    state_nx = CLEAR;
                end else if (press_write) begin
                    state_nx = WRITE;
                end
            end
            WRITE:   state_nx = HOLD;
            CLEAR: begin
                if (wraddress == LAST_ADDR) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (level_write && level_clear) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The write port registers double as the latches for address, data and sweep position.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            wren        <= 1'b0;
            wraddress   <= '0;
            data        <= '0;
            last_addr   <= '0;
            write_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_clear) begin
                        wren      <= 1'b1;
                        wraddress <= '0;
                        data      <= fill_value;
                    end else if (press_write) begin
                        wren      <= 1'b1;
                        wraddress <= single_addr;
                        data      <= sw_data;
                    end
                end
                WRITE: begin
                    wren      <= 1'b0;
                    last_addr <= wraddress;
                    if (write_count != 8'hFF) begin
                        write_count <= write_count + 8'd1;
                    end
                end
                CLEAR: begin
                    if (wraddress == LAST_ADDR) begin
                        wren        <= 1'b0;
                        write_count <= '0;
                        last_addr   <= LAST_ADDR;
                    end else begin
                        wraddress <= wraddress + 1'b1;
                    end
                end
                default: wren <= 1'b0;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ram_write_ctrl.sv
// Bench for ram_write_ctrl with a short debounce: a queue of expected RAM writes and a
// transaction-level model of counters/pointer, checked by a negedge monitor every cycle.
module tb_ram_write_ctrl;

    localparam int N     = 4;
    localparam int DEPTH = 32;
`ifdef WRITE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       RESET_N;
    logic       key_write_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic [4:0] sw_addr     = '0;
    logic [3:0] sw_data     = '0;
    logic [3:0] fill_value  = '0;
    logic       wren;
    logic [4:0] wraddress;
    logic [3:0] data;
    logic       busy;
    logic [4:0] last_addr;
    logic [7:0] write_count;

    ram_write_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .CLOCK_50    (clk),
        .RESET_N     (RESET_N),
        .key_write_n (key_write_n),
        .key_clear_n (key_clear_n),
        .sw_addr     (sw_addr),
        .sw_data     (sw_data),
        .fill_value  (fill_value),
        .wren        (wren),
        .wraddress   (wraddress),
        .data        (data),
        .busy        (busy),
        .last_addr   (last_addr),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0] q_addr[$];
    logic [3:0] q_data[$];
    bit         q_cont[$];
    logic [4:0] m_wraddr = '0;
    logic [3:0] m_data   = '0;
    logic [4:0] m_last   = '0;
    int         m_count  = 0;
    int         m_ptr    = 0;
    bit         must_follow = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (RESET_N === 1'b0) begin
            chk("reset_wren", wren, 0);
            chk("reset_wraddress", wraddress, 0);
            chk("reset_data", data, 0);
            chk("reset_busy", busy, 0);
            must_follow = 1'b0;
        end else if (RESET_N === 1'b1) begin
            if (wren === 1'b1) begin
                if (q_addr.size() == 0) begin
                    chk("unexpected_wren", wren, 0);
                end else begin
                    logic [4:0] ea;
                    logic [3:0] ed;
                    ea = q_addr.pop_front();
                    ed = q_data.pop_front();
                    chk("wr_addr", wraddress, ea);
                    chk("wr_data", data, ed);
                    chk("busy_during_wren", busy, 1);
                    m_wraddr    = ea;
                    m_data      = ed;
                    must_follow = q_cont.pop_front();
                end
            end else begin
                if (must_follow) chk("sweep_gap", wren, 1);
                must_follow = 1'b0;
                chk("idle_wraddress_hold", wraddress, m_wraddr);
                chk("idle_data_hold", data, m_data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts posedges from the key edge until wren is seen; returns positioned at a negedge.
    task automatic wait_wren(output int lat);
        lat = 0;
        forever begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (wren === 1'b1 || lat >= N + 8) break;
        end
        chk("first_wren_latency_ok", (wren === 1'b1) && (lat <= N + 4), 1);
    endtask

    task automatic wait_idle(input int limit);
        int c = 0;
        @(negedge clk);
        while (busy !== 1'b0 && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk("busy_release", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [3:0] d, input int hold);
        logic [4:0] ea;
        int lat;
        sw_addr = a;
        sw_data = d;
        ea = AUTOINC ? 5'(m_ptr) : a;
        q_addr.push_back(ea);
        q_data.push_back(d);
        q_cont.push_back(1'b0);
        key_write_n = 1'b0;
        wait_wren(lat);
        @(posedge clk);
        #1;
        sw_addr = 5'($urandom_range(0, 31));
        sw_data = 4'($urandom_range(0, 15));
        tick(hold);
        chk("busy_while_key_held", busy, 1);
        key_write_n = 1'b1;
        wait_idle(N + 6);
        m_last = ea;
        if (m_count < 255) m_count++;
        m_ptr = (m_ptr + 1) % DEPTH;
        chk("write_count", write_count, 32'(m_count));
        chk("last_addr", last_addr, m_last);
    endtask

    task automatic do_clear(input logic [3:0] f, input bit with_write);
        int lat;
        fill_value = f;
        for (int i = 0; i < DEPTH; i++) begin
            q_addr.push_back(5'(i));
            q_data.push_back(f);
            q_cont.push_back(i != DEPTH - 1);
        end
        key_clear_n = 1'b0;
        if (with_write) key_write_n = 1'b0;
        wait_wren(lat);
        @(posedge clk);
        #1;
        fill_value  = 4'($urandom_range(0, 15));
        sw_addr     = 5'($urandom_range(0, 31));
        key_clear_n = 1'b1;
        if (with_write) begin
            tick(100);
            chk("hold_while_write_key_down", busy, 1);
            key_write_n = 1'b1;
        end
        wait_idle(DEPTH + N + 10);
        m_count = 0;
        m_last  = 5'(DEPTH - 1);
        m_ptr   = 0;
        chk("clear_write_count", write_count, 32'(m_count));
        chk("clear_last_addr", last_addr, m_last);
    endtask

    task automatic set_key(input bit on_clear, input logic v);
        if (on_clear) key_clear_n = v;
        else          key_write_n = v;
    endtask

    // Low pulses shorter than the debounce window must never produce a write.
    task automatic glitch(input bit on_clear, input int pairs, input bit fixed2);
        for (int p = 0; p < pairs; p++) begin
            set_key(on_clear, 1'b0);
            tick(fixed2 ? 2 : $urandom_range(1, N - 1));
            set_key(on_clear, 1'b1);
            tick(fixed2 ? 2 : $urandom_range(1, 3));
        end
        tick(N + 16);
        chk("no_busy_after_glitch", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lits[3];
        bit  found;
        int  lat;
        lits = '{5, 17, 30};
        RESET_N = 1'b1;
        #1;
        RESET_N = 1'b0;
        tick(4);
        RESET_N = 1'b1;
        tick(2);
        chk("lit_reset_wren", wren, 0);
        chk("lit_reset_wraddress", wraddress, 0);
        chk("lit_reset_data", data, 0);
        chk("lit_reset_busy", busy, 0);
        chk("lit_reset_write_count", write_count, 0);
        chk("lit_reset_last_addr", last_addr, 0);

        do_write(5'd7, 4'hA, 3);
        chk("lit_first_write_count", write_count, 1);
        chk("lit_first_last_addr", last_addr, AUTOINC ? 0 : 7);

        glitch(1'b0, 5, 1'b1);

        do_clear(4'd3, 1'b0);
        chk("lit_clear_count", write_count, 0);
        chk("lit_clear_last", last_addr, 31);

        do_clear(4'($urandom_range(0, 15)), 1'b1);
        do_write(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 2);

        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 3))
                0:       glitch(1'($urandom_range(0, 1)), $urandom_range(1, 6), 1'b0);
                3:       do_clear(4'($urandom_range(0, 15)), 1'b0);
                default: do_write(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
                                  $urandom_range(0, 12));
            endcase
        end

        for (int i = 0; i < 256; i++) begin
            do_write(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 0);
        end
        chk("lit_saturated_count", write_count, 255);

        fill_value = 4'($urandom_range(0, 15));
        for (int i = 0; i < DEPTH; i++) begin
            q_addr.push_back(5'(i));
            q_data.push_back(fill_value);
            q_cont.push_back(i != DEPTH - 1);
        end
        key_clear_n = 1'b0;
        wait_wren(lat);
        @(posedge clk);
        #1;
        key_clear_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            @(negedge clk);
            if (wren === 1'b1 && wraddress == 5'd10) begin
                found = 1'b1;
                break;
            end
        end
        chk("sweep_reaches_10", found, 1);
        #2;
        RESET_N = 1'b0;
        q_addr.delete();
        q_data.delete();
        q_cont.delete();
        m_wraddr = '0;
        m_data   = '0;
        m_last   = '0;
        m_count  = 0;
        m_ptr    = 0;
        #1;
        chk("lit_wren_drops_async", wren, 0);
        chk("lit_busy_drops_async", busy, 0);
        tick(3);
        RESET_N = 1'b1;
        tick(50);
        chk("lit_post_reset_count", write_count, 0);
        chk("lit_post_reset_last", last_addr, 0);
        chk("lit_post_reset_busy", busy, 0);

        for (int i = 0; i < 3; i++) begin
            do_write(5'(lits[i]), 4'($urandom_range(0, 15)), 1);
            chk("lit_post_reset_write_addr", last_addr, AUTOINC ? i : lits[i]);
        end
        chk("lit_post_reset_three", write_count, 3);
        chk("queue_drained", q_addr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_write_ctrl.md
Name: ram_write_ctrl

Overview:
- Write-side controller for the 32x4 dual-port RAM, the counterpart to the sequential read/display scanner.
- Turns pushbutton presses into clean single-cycle RAM write strobes. Supports two operations:
  - single write from switch address/data;
  - full-memory clear sweep with a fill value.
- Drives the RAM's wren/wraddress/data port; status outputs feed the HEX display logic.

Parameters:
- ADDR_W, 5, RAM address width
- DATA_W, 4, RAM data width
- DEPTH, 32, number of RAM words; clear sweeps 0..DEPTH-1
- DEBOUNCE_CYCLES, 500000, cycles a key must be stable before it is accepted (10 ms at 50 MHz)

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- RESET_N  in  1  asynchronous active-low reset
- key_write_n  in  1  raw pushbutton, active-low, asynchronous to CLOCK_50; requests a single write
- key_clear_n  in  1  raw pushbutton, active-low, asynchronous; requests a clear sweep
- sw_addr  in  ADDR_W  target address for a single write
- sw_data  in  DATA_W  data for a single write
- fill_value  in  DATA_W  data written by the clear sweep
- wren  out  1  RAM write enable
- wraddress  out  ADDR_W  RAM write address
- data  out  DATA_W  RAM write data
- busy  out  1  high whenever the FSM is not IDLE
- last_addr  out  ADDR_W  last address written by a single write
- write_count  out  8  number of single writes since the last clear or reset; saturates at 255

Behaviour:
- Clock and reset: one clock, CLOCK_50. RESET_N is asynchronous, active-low.
- Reset:
  - state=IDLE, all outputs 0;
  - synchronizers and debounced key levels = 1 (released).
- Key path, per key:
  - 2-FF synchronizer, then debounce.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles in which the synchronized level differs from it; any agreeing cycle restarts the count.
  - A press event is a one-cycle pulse on the debounced 1->0 edge.
- FSM states: IDLE, WRITE, CLEAR, HOLD.
- IDLE:
  - press_clear -> CLEAR; latch fill_value; sweep address = 0.
  - else press_write -> WRITE; latch sw_addr and sw_data.
  - Simultaneous presses: clear wins and the write is dropped.
- WRITE:
  - wren=1 for exactly one cycle with the latched address/data.
  - last_addr <= address; write_count <= write_count+1, saturating at 255.
  - Next state: HOLD.
- CLEAR:
  - wren=1 for DEPTH consecutive cycles; wraddress = 0,1,...,DEPTH-1; data = latched fill_value.
  - After address DEPTH-1: next state HOLD, write_count <= 0, last_addr <= DEPTH-1.
- HOLD: stay until both debounced keys are released (1), then IDLE.
  - Holding a key never causes a repeat write.
- Press events in WRITE, CLEAR or HOLD are ignored.
- Latency:
  - press pulse in cycle t -> first wren in cycle t+1.
  - Raw key edge to wren is at most DEBOUNCE_CYCLES+4 cycles.
- Registered outputs:
  - wren, wraddress and data are registered.
  - While wren=0, wraddress and data hold their last values.
- Sweep address: counts 0..DEPTH-1 and never wraps inside a single sweep.
- Reset mid-sweep: RESET_N low drops wren immediately (asynchronously) and the sweep aborts. After release: IDLE, no resumption.
- sw_addr/sw_data changes after the latch do not affect a write in progress.

Optional Feature:
- Macro: WRITE_AUTOINC_EN.
- Defined:
  - single writes ignore sw_addr and use an internal pointer;
  - pointer resets to 0, increments after each single write, wraps DEPTH-1 -> 0;
  - a clear sweep resets the pointer to 0.
- Undefined: the single-write address comes from sw_addr. No pointer register exists.

Decomposition:
- Package ram_wr_pkg:
  - ADDR_W, DATA_W, DEPTH defaults;
  - FSM state typedef (IDLE/WRITE/CLEAR/HOLD).
- Sub-module key_debounce: synchronizer + debounce counter + falling-edge pulse. Ports: CLOCK_50, RESET_N, key_n, level, press. Instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, keys released -> wren=0, wraddress=0, data=0, busy=0, write_count=0, last_addr=0.
- sw_addr=7, sw_data=4'hA, key_write_n held low 10 cycles -> exactly one wren cycle with wraddress=7, data=A; write_count=1, last_addr=7; busy high until key release plus debounce.
- key_write_n toggling every 2 cycles for 20 cycles, then released -> zero wren cycles.
- fill_value=3, key_clear_n pressed -> 32 consecutive wren cycles, addresses 0..31, data=3; then write_count=0, last_addr=31.
- Both keys pressed in the same cycle -> clear sweep only. Key_write_n then held 100 cycles -> no further wren until it is released and pressed again.
- RESET_N asserted while wraddress=10 during a sweep -> wren=0 in the same cycle, no writes after release. With WRITE_AUTOINC_EN: three writes -> addresses 0,1,2.
